fwrisc_dbus_rsp: RTL and testbench



---
 rtl/fwrisc_dbus_rsp.sv | 154 +++++++++++++++
 tb/tb_fwrisc_dbus_rsp.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_dbus_rsp.sv
// Data-bus response tracker: waits for dready under a watchdog, checks alignment,
// and formats load data into a registered, single-cycle register-file write.
module fwrisc_dbus_rsp #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [31:0] instr_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        dvalid_i,
  input  logic        dwrite_i,
  input  logic        dready_i,
  input  logic [31:0] drdata_i,
  output logic [31:0] rd_wdata_o,
  output logic        rd_we_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone, StFault} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        dwrite_q;
  logic [31:0] rd_wdata_q;
  logic        rd_we_q;
  logic        done_q;
  logic        misalign_q;
  logic        bus_err_q;

  logic [2:0]  sel_funct3;
  logic [1:0]  sel_addr;
  logic        sel_write;
  logic        req_misalign;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;
  logic        unused_instr;

  assign unused_instr = ^{instr_i[31:15], instr_i[11:0]};

  // In IDLE the access completes in the accept cycle, so use live inputs there.
  always_comb begin
    sel_funct3 = funct3_q;
    sel_addr   = addr_lo_q;
    sel_write  = dwrite_q;
    if (state_q == StIdle) begin
      sel_funct3 = instr_i[14:12];
      sel_addr   = addr_lo_i;
      sel_write  = dwrite_i;
    end
  end

  // funct3[1] set means word size, including the reserved encodings.
  always_comb begin
    req_misalign = 1'b0;
    if (instr_i[13]) begin
      req_misalign = (addr_lo_i != 2'b00);
    end else if (instr_i[12]) begin
      req_misalign = addr_lo_i[0];
    end
  end

  always_comb begin
    sel_byte  = drdata_i[{sel_addr, 3'b000} +: 8];
    sel_half  = sel_addr[1] ? drdata_i[31:16] : drdata_i[15:0];
    load_data = drdata_i;
    case (sel_funct3)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  load_data = {24'h0, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b101:  load_data = {16'h0, sel_half};
      default: load_data = drdata_i;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      funct3_q   <= 3'b000;
      addr_lo_q  <= 2'b00;
      dwrite_q   <= 1'b0;
      rd_wdata_q <= 32'h0;
      rd_we_q    <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      rd_we_q    <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (dvalid_i) begin
            funct3_q  <= instr_i[14:12];
            addr_lo_q <= addr_lo_i;
            dwrite_q  <= dwrite_i;
            if (req_misalign) begin
              state_q    <= StFault;
              misalign_q <= 1'b1;
            end else if (dready_i) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              if (!sel_write) begin
                rd_we_q    <= 1'b1;
                rd_wdata_q <= load_data;
              end
            end else begin
              state_q <= StWait;
              cnt_q   <= 8'd1;
            end
          end
        end
        StWait: begin
          if (!dvalid_i) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
          end else if (dready_i) begin
            state_q <= StDone;
            cnt_q   <= 8'd0;
            done_q  <= 1'b1;
            if (!sel_write) begin
              rd_we_q    <= 1'b1;
              rd_wdata_q <= load_data;
            end
          end else if (cnt_q >= TimeoutLast) begin
            state_q   <= StFault;
            cnt_q     <= 8'd0;
            bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone:  state_q <= StIdle;
        StFault: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_wdata_o = rd_wdata_q;
  assign rd_we_o    = rd_we_q;
  assign done_o     = done_q;
  assign misalign_o = misalign_q;
  assign bus_err_o  = bus_err_q;

endmodule

// File: tb/tb_fwrisc_dbus_rsp.sv
// Randomized bench for fwrisc_dbus_rsp; expected per-cycle outputs come from a
// transaction-level model of alignment, timeout and load-format rules.
module tb_fwrisc_dbus_rsp;

  localparam int unsigned Timeout = 16;

  logic        clock;
  logic        reset;
  logic [31:0] instr;
  logic [1:0]  addr_lo;
  logic        dvalid;
  logic        dwrite;
  logic        dready;
  logic [31:0] drdata;
  logic [31:0] rd_wdata;
  logic        rd_we;
  logic        done;
  logic        misalign;
  logic        bus_err;

  fwrisc_dbus_rsp #(.TIMEOUT(Timeout)) dut (
    .clock_i    (clock),
    .reset_i    (reset),
    .instr_i    (instr),
    .addr_lo_i  (addr_lo),
    .dvalid_i   (dvalid),
    .dwrite_i   (dwrite),
    .dready_i   (dready),
    .drdata_i   (drdata),
    .rd_wdata_o (rd_wdata),
    .rd_we_o    (rd_we),
    .done_o     (done),
    .misalign_o (misalign),
    .bus_err_o  (bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  // Sample = {rd_wdata, rd_we, done, misalign, bus_err}
  logic [35:0] exp_q[$];
  logic [35:0] obs_q[$];
  logic [31:0] model_rd;

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    int unsigned size;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    return (int'(a) % size) != 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * int'(a))) & 32'hFF;
    h = (d >> (16 * (int'(a) / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  // Append the expected trace: one sample per cycle after accept, through the
  // return to IDLE. An access fails after Timeout consecutive cycles without dready.
  task automatic expect_access(input logic [2:0] f3, input logic [1:0] a, input bit wr,
                               input logic [31:0] d, input int wait_n, output int ncyc);
    bit mis;
    int ev;
    mis  = is_misaligned(f3, a);
    ev   = mis ? 0 : ((wait_n < int'(Timeout)) ? wait_n : int'(Timeout) - 1);
    ncyc = ev + 2;
    for (int k = 0; k < ncyc; k++) begin
      logic [3:0] p;
      p = 4'b0000;
      if (k == ev) begin
        if (mis) p = 4'b0010;
        else if (wait_n < int'(Timeout)) begin
          p = wr ? 4'b0100 : 4'b1100;
          if (!wr) model_rd = load_val(f3, a, d);
        end else p = 4'b0001;
      end
      exp_q.push_back({model_rd, p});
    end
  endtask

  // Acts as the core: holds the request until a pulse is seen, then drops it.
  task automatic run_access(input logic [2:0] f3, input logic [1:0] a, input bit wr,
                            input logic [31:0] d, input int wait_n, input int ncyc);
    instr         = $urandom;
    instr[14:12]  = f3;
    addr_lo       = a;
    dwrite        = wr;
    drdata        = d;
    dvalid        = 1'b1;
    dready        = (wait_n == 0);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clock);
      #1;
      obs_q.push_back({rd_wdata, rd_we, done, misalign, bus_err});
      if (done || misalign || bus_err || !dvalid) begin
        dvalid = 1'b0;
        dready = 1'b0;
        drdata = $urandom;
      end else begin
        dready = ((k + 1) == wait_n);
      end
    end
  endtask

  task automatic access(input logic [2:0] f3, input logic [1:0] a, input bit wr,
                        input logic [31:0] d, input int wait_n);
    int n;
    expect_access(f3, a, wr, d, wait_n, n);
    run_access(f3, a, wr, d, wait_n, n);
  endtask

  task automatic step_idle(input logic [3:0] pulses);
    @(posedge clock);
    #1;
    obs_q.push_back({rd_wdata, rd_we, done, misalign, bus_err});
    exp_q.push_back({model_rd, pulses});
  endtask

  task automatic test_reset;
    exp_q.delete(); obs_q.delete();
    reset = 1'b1; dvalid = 1'b1; dready = 1'b1; dwrite = 1'b0;
    instr = 32'h0; addr_lo = 2'b00; drdata = 32'hDEAD_BEEF;
    model_rd = 32'h0;
    step_idle(4'b0000);
    step_idle(4'b0000);
    reset = 1'b0; dvalid = 1'b0; dready = 1'b0;
    step_idle(4'b0000);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %h/%b required %h/%b", i,
                 obs_q[i][35:4], obs_q[i][3:0], exp_q[i][35:4], exp_q[i][3:0]);
      end
    end
  endtask

  task automatic test_load_format;
    exp_q.delete(); obs_q.delete();
    access(3'b000, 2'd3, 1'b0, 32'h80AA_BBCC, 0);
    access(3'b100, 2'd3, 1'b0, 32'h80AA_BBCC, 0);
    access(3'b001, 2'd2, 1'b0, 32'h1234_5678, 3);
    access(3'b001, 2'd2, 1'b0, 32'h8001_0000, 3);
    access(3'b101, 2'd0, 1'b0, 32'h0000_9ABC, 1);
    access(3'b010, 2'd0, 1'b0, 32'hCAFE_F00D, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL load_format cycle %0d: got %h/%b required %h/%b", i,
                 obs_q[i][35:4], obs_q[i][3:0], exp_q[i][35:4], exp_q[i][3:0]);
      end
    end
  endtask

  task automatic test_store_misalign;
    exp_q.delete(); obs_q.delete();
    access(3'b010, 2'd0, 1'b1, 32'h5555_AAAA, 1);
    access(3'b010, 2'd2, 1'b0, 32'h1111_2222, 0);
    access(3'b001, 2'd1, 1'b1, 32'h3333_4444, 0);
    access(3'b111, 2'd3, 1'b0, 32'h7777_8888, 2);
    access(3'b100, 2'd1, 1'b0, 32'h00FF_7F00, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL store_misalign cycle %0d: got %h/%b required %h/%b", i,
                 obs_q[i][35:4], obs_q[i][3:0], exp_q[i][35:4], exp_q[i][3:0]);
      end
    end
  endtask

  task automatic test_timeout;
    exp_q.delete(); obs_q.delete();
    access(3'b010, 2'd0, 1'b0, 32'h0BAD_0BAD, 1000);
    access(3'b000, 2'd1, 1'b0, 32'h0000_F100, 0);
    access(3'b010, 2'd0, 1'b0, 32'h1357_9BDF, Timeout - 1);
    access(3'b010, 2'd0, 1'b1, 32'h2468_ACE0, Timeout);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: got %h/%b required %h/%b", i,
                 obs_q[i][35:4], obs_q[i][3:0], exp_q[i][35:4], exp_q[i][3:0]);
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_q.delete(); obs_q.delete();
    instr = 32'h0000_2003; addr_lo = 2'd0; dwrite = 1'b0; drdata = 32'h9999_9999;
    dvalid = 1'b1; dready = 1'b0;
    for (int k = 0; k < 5; k++) step_idle(4'b0000);
    reset = 1'b1;
    model_rd = 32'h0;
    step_idle(4'b0000);
    reset = 1'b0; dvalid = 1'b0;
    step_idle(4'b0000);
    step_idle(4'b0000);
    access(3'b001, 2'd0, 1'b0, 32'h0000_8765, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_mid cycle %0d: got %h/%b required %h/%b", i,
                 obs_q[i][35:4], obs_q[i][3:0], exp_q[i][35:4], exp_q[i][3:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_q.delete(); obs_q.delete();
    for (int t = 0; t < 60; t++) begin
      logic [2:0]  f3;
      logic [1:0]  a;
      bit          wr;
      logic [31:0] d;
      int          w;
      f3 = 3'($urandom);
      a  = 2'($urandom);
      wr = 1'($urandom);
      d  = $urandom;
      w  = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 4));
      access(f3, a, wr, d, w);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %h/%b required %h/%b", i,
                 obs_q[i][35:4], obs_q[i][3:0], exp_q[i][35:4], exp_q[i][3:0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; dvalid = 1'b0; dready = 1'b0; dwrite = 1'b0;
    instr = 32'h0; addr_lo = 2'b00; drdata = 32'h0;
    model_rd = 32'h0;
    @(negedge clock);
    test_reset;
    test_load_format;
    test_store_misalign;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
